// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the core
// load/store unit (port 0) and a secondary master (port 1).
// One request is in flight at a time; memory strobes and responses are registered.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins
// every contention). Leave it undefined for round-robin arbitration.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no request owned; accept the arbitration winner
// ISSUE  | memory strobe high for one cycle; write response pulses here
// RDWAIT | dmem read data valid; capture it and pulse the read response
module dmem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  input  logic          req0_write_i,
  input  logic [AW-1:0] req0_addr_i,
  input  logic [DW-1:0] req0_wdata_i,
  output logic          rsp0_valid_o,
  output logic [DW-1:0] rsp0_rdata_o,
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  input  logic          req1_write_i,
  input  logic [AW-1:0] req1_addr_i,
  input  logic [DW-1:0] req1_wdata_i,
  output logic          rsp1_valid_o,
  output logic [DW-1:0] rsp1_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_write_o,
  output logic          mem_read_o,
  input  logic [DW-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t        state;
  logic          owner;
  logic          lat_write;
  logic          grant_sel;
  logic          accept;
  logic          sel_write;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic          last_grant;
`endif

  // Pick a winner; ready is combinational, only in IDLE, and suppressed under reset.
  always_comb begin
    grant_sel = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      grant_sel = 1'b0;
`else
      grant_sel = ~last_grant;
`endif
    end else begin
      grant_sel = ~req0_valid_i;
    end
    accept       = (state == IDLE) && (req0_valid_i || req1_valid_i) && !rst;
    req0_ready_o = accept && !grant_sel;
    req1_ready_o = accept && grant_sel;
    sel_write    = grant_sel ? req1_write_i : req0_write_i;
    sel_addr     = grant_sel ? req1_addr_i  : req0_addr_i;
    sel_wdata    = grant_sel ? req1_wdata_i : req0_wdata_i;
  end

  // Sequencer: latch the winner, strobe dmem, route the response to the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      lat_write    <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant   <= 1'b1;
`endif
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_write_o  <= 1'b0;
      mem_read_o   <= 1'b0;
      rsp0_valid_o <= 1'b0;
      rsp1_valid_o <= 1'b0;
      rsp0_rdata_o <= '0;
      rsp1_rdata_o <= '0;
    end else begin
      mem_write_o  <= 1'b0;
      mem_read_o   <= 1'b0;
      rsp0_valid_o <= 1'b0;
      rsp1_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner       <= grant_sel;
            lat_write   <= sel_write;
            mem_addr_o  <= sel_addr;
            mem_wdata_o <= sel_wdata;
            mem_write_o <= sel_write;
            mem_read_o  <= !sel_write;
            // A write completes with its strobe, so its pulse lands in ISSUE.
            if (sel_write) begin
              rsp0_valid_o <= !grant_sel;
              rsp1_valid_o <= grant_sel;
            end
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_grant  <= grant_sel;
`endif
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          state <= lat_write ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          if (owner) begin
            rsp1_valid_o <= 1'b1;
            rsp1_rdata_o <= mem_rdata_i;
          end else begin
            rsp0_valid_o <= 1'b1;
            rsp0_rdata_o <= mem_rdata_i;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: drivers push expectations into queues, one monitor
// on the falling edge pops and compares whenever the DUT presents an output.
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req0_write = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_write = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write, mem_read;
  logic [DW-1:0] mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_write_i(req0_write),
    .req0_addr_i(req0_addr), .req0_wdata_i(req0_wdata),
    .rsp0_valid_o(rsp0_valid), .rsp0_rdata_o(rsp0_rdata),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_write_i(req1_write),
    .req1_addr_i(req1_addr), .req1_wdata_i(req1_wdata),
    .rsp1_valid_o(rsp1_valid), .rsp1_rdata_o(rsp1_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_write_o(mem_write), .mem_read_o(mem_read),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // dmem model: one-cycle registered read
  logic [DW-1:0] dmem [256];
  always @(posedge clk) begin
    if (mem_write) dmem[mem_addr[7:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= dmem[mem_addr[7:0]];
  end

  typedef struct { bit wr; logic [15:0] rd; } rsp_exp_t;
  typedef struct { bit wr; logic [15:0] addr; logic [15:0] wdata; } mem_exp_t;

  rsp_exp_t rsp_q0[$];
  rsp_exp_t rsp_q1[$];
  mem_exp_t mem_q[$];
  bit       grant_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_rd_cyc = -100;
  logic [15:0] last_rd0 = 16'h0000;
  logic [15:0] last_rd1 = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic handle_rsp(input int p, input logic [15:0] act_rd);
    rsp_exp_t e;
    bit       empty;
    empty = (p == 0) ? (rsp_q0.size() == 0) : (rsp_q1.size() == 0);
    if (empty) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rsp%0d_unexpected: got a pulse, want none (cycle %0d)", p, cyc);
      return;
    end
    if (p == 0) e = rsp_q0.pop_front();
    else        e = rsp_q1.pop_front();
    if (e.wr) begin
      check($sformatf("wr_rsp%0d_with_strobe", p), {31'd0, mem_write}, 32'd1);
      check($sformatf("rdata%0d_hold", p), {16'd0, act_rd}, {16'd0, (p == 0) ? last_rd0 : last_rd1});
    end else begin
      check($sformatf("rd%0d_data", p), {16'd0, act_rd}, {16'd0, e.rd});
      check($sformatf("rd%0d_latency", p), cyc - last_rd_cyc, 32'd2);
      if (p == 0) last_rd0 = e.rd;
      else        last_rd1 = e.rd;
    end
  endtask

  // Monitor: compare every strobe, grant and response against the queues.
  always @(negedge clk) begin
    mem_exp_t m;
    bit       g;
    if (mem_write || mem_read) begin
      check("strobe_exclusive", {31'd0, mem_write & mem_read}, 32'd0);
      if (mem_read) last_rd_cyc = cyc;
      if (mem_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL mem_unexpected: got strobe addr 0x%0h, want none", mem_addr);
      end else begin
        m = mem_q.pop_front();
        check("mem_is_write", {31'd0, mem_write}, {31'd0, m.wr});
        check("mem_addr", {16'd0, mem_addr}, {16'd0, m.addr});
        if (m.wr) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, m.wdata});
      end
    end
    if (req0_ready || req1_ready) begin
      check("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (grant_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL grant_unexpected: got ready, want none (cycle %0d)", cyc);
      end else begin
        g = grant_q.pop_front();
        check("grant_port", {31'd0, req1_ready}, {31'd0, g});
      end
    end
    if (rsp0_valid || rsp1_valid) begin
      check("rsp_exclusive", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
      if (rsp0_valid) handle_rsp(0, rsp0_rdata);
      if (rsp1_valid) handle_rsp(1, rsp1_rdata);
    end
  end

  task automatic drive(input int p, input bit v, input bit w, input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end
  endtask

  // Issue one request, hold it until ready, then scramble the inputs and wait for the response.
  task automatic do_req(input int p, input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] rd_exp, output int waited);
    rsp_exp_t e;
    mem_exp_t m;
    bit       got;
    logic     flag;
    e.wr = wr;
    e.rd = rd_exp;
    if (p == 0) rsp_q0.push_back(e);
    else        rsp_q1.push_back(e);
    @(posedge clk); #1;
    drive(p, 1'b1, wr, a, d);
    got = 1'b0;
    waited = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      flag = (p == 0) ? req0_ready : req1_ready;
      if (flag) begin
        got = 1'b1;
        m.wr = wr; m.addr = a; m.wdata = d;
        mem_q.push_back(m);
      end else begin
        waited++;
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL accept%0d_timeout: got no ready, want ready within 40 cycles", p);
    end
    @(posedge clk); #1;
    drive(p, 1'b0, ~wr, a ^ 16'hFFFF, d ^ 16'hFFFF);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      flag = (p == 0) ? rsp0_valid : rsp1_valid;
      if (flag) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp%0d_timeout: got no response, want one within 40 cycles", p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, w1;
    mem_exp_t m;
    bit got;

    // Reset values, and a request coinciding with reset is not accepted
    repeat (2) @(posedge clk);
    #1 req0_valid = 1'b1;
    @(negedge clk);
    check("rst_wins_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_strobes", {30'd0, mem_write, mem_read}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    check("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 32'd0);
    check("rst_rdata", {rsp0_rdata, rsp1_rdata}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    check("no_accept_in_rst", {30'd0, mem_write, mem_read}, 32'd0);

    // Port 0 write then read back
    grant_q.push_back(1'b0);
    do_req(0, 1'b1, 16'h0000, 16'hABCD, 16'h0000, w0);
    grant_q.push_back(1'b0);
    do_req(0, 1'b0, 16'h0000, 16'h0000, 16'hABCD, w0);

    // Port 1 write then read back
    grant_q.push_back(1'b1);
    do_req(1, 1'b1, 16'h0010, 16'h1234, 16'h0000, w1);
    grant_q.push_back(1'b1);
    do_req(1, 1'b0, 16'h0010, 16'h0000, 16'h1234, w1);

    // Simultaneous reads: port 0 first, then port 1, each with its own data
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b1);
    fork
      do_req(0, 1'b0, 16'h0000, 16'h0000, 16'hABCD, w0);
      do_req(1, 1'b0, 16'h0010, 16'h0000, 16'h1234, w1);
    join

    // Both ports keep requesting: three writes each
`ifdef DMEM_ARB_FIXED_PRIO_EN
    grant_q.push_back(1'b0); grant_q.push_back(1'b0); grant_q.push_back(1'b0);
    grant_q.push_back(1'b1); grant_q.push_back(1'b1); grant_q.push_back(1'b1);
`else
    grant_q.push_back(1'b0); grant_q.push_back(1'b1); grant_q.push_back(1'b0);
    grant_q.push_back(1'b1); grant_q.push_back(1'b0); grant_q.push_back(1'b1);
`endif
    fork
      begin
        int wa;
        do_req(0, 1'b1, 16'h0040, 16'h1111, 16'h0000, wa);
        do_req(0, 1'b1, 16'h0041, 16'h2222, 16'h0000, wa);
        do_req(0, 1'b1, 16'h0042, 16'h3333, 16'h0000, wa);
      end
      begin
        int wb;
        do_req(1, 1'b1, 16'h0050, 16'h00A1, 16'h0000, wb);
        do_req(1, 1'b1, 16'h0051, 16'h00A2, 16'h0000, wb);
        do_req(1, 1'b1, 16'h0052, 16'h00A3, 16'h0000, wb);
      end
    join

    // Reset during ISSUE of a read: strobe seen once, no response afterwards
    grant_q.push_back(1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req0_ready) begin
        got = 1'b1;
        m.wr = 1'b0; m.addr = 16'h0000; m.wdata = 16'h0000;
        mem_q.push_back(m);
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL rst_test_accept: got no ready, want ready");
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd0 = 16'h0000;
    last_rd1 = 16'h0000;
    @(negedge clk);
    check("post_rst_strobes", {30'd0, mem_write, mem_read}, 32'd0);
    check("post_rst_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    repeat (5) @(negedge clk);

    // First contention after reset goes to port 0, with no wait
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b1);
    fork
      do_req(0, 1'b0, 16'h0000, 16'h0000, 16'hABCD, w0);
      do_req(1, 1'b0, 16'h0010, 16'h0000, 16'h1234, w1);
    join
    check("post_rst_accept_wait", w0, 32'd0);

    // Port 0 write held off by a port 1 read; inputs scrambled after acceptance
    grant_q.push_back(1'b1);
    grant_q.push_back(1'b0);
    fork
      do_req(1, 1'b0, 16'h0010, 16'h0000, 16'h1234, w1);
      begin
        @(posedge clk);
        do_req(0, 1'b1, 16'h0020, 16'h5555, 16'h0000, w0);
      end
    join
    check("held_req_wait", w0, 32'd2);
    grant_q.push_back(1'b0);
    do_req(0, 1'b0, 16'h0020, 16'h0000, 16'h5555, w0);
    grant_q.push_back(1'b1);
    do_req(1, 1'b0, 16'h0041, 16'h0000, 16'h2222, w1);

    repeat (5) @(negedge clk);
    check("rsp_q_drained", rsp_q0.size() + rsp_q1.size(), 32'd0);
    check("mem_q_drained", mem_q.size(), 32'd0);
    check("grant_q_drained", grant_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
